packoutput: RTL

//  Inverse of the FPU input unpacker: packs an internal result (sign, exponent in largest-precision bias,

---
 rtl/packoutput_pkg.sv | 48 ++++
 rtl/packoutput_if.sv | 36 +++
 rtl/packrebias.sv | 73 +++++++
 rtl/packoutput.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/packoutput_pkg.sv
// packoutput_pkg
// Purpose : shared constants and types for the FP result packer (RV64 D+S+H configuration).
//           Provides the format encodings, per-format field sizes and biases, derived widths
//           for the rebias/denormalise datapath, and the pack class enum.
// Ports   : none (package).
package packoutput_pkg;

    localparam int unsigned FLEN    = 64;
    localparam int unsigned NE      = 11;
    localparam int unsigned NF      = 52;
    localparam int unsigned BIAS    = 1023;
    localparam int unsigned FMTBITS = 2;

    localparam int unsigned S_LEN  = 32;
    localparam int unsigned S_NE   = 8;
    localparam int unsigned S_NF   = 23;
    localparam int unsigned S_BIAS = 127;

    localparam int unsigned H_LEN  = 16;
    localparam int unsigned H_NE   = 5;
    localparam int unsigned H_NF   = 10;
    localparam int unsigned H_BIAS = 15;

    // Largest denormalising shift (double), shift-amount width, signed rebias width,
    // and width of the shifted fraction window (leading bit excluded).
    localparam int unsigned SHMAX = NF + 2;
    localparam int unsigned SHW   = $clog2(SHMAX + 1);
    localparam int unsigned EW    = NE + 2;
    localparam int unsigned XW    = NF + SHMAX;

    localparam logic [FMTBITS-1:0] FMT_S = 2'b00;
    localparam logic [FMTBITS-1:0] FMT_D = 2'b01;
    localparam logic [FMTBITS-1:0] FMT_H = 2'b10;
    localparam logic [FMTBITS-1:0] FMT_Q = 2'b11;

    // Canonical NaN at full register width; also the answer for unsupported formats.
    localparam logic [FLEN-1:0] CANON_NAN_FLEN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        PK_NORM,
        PK_SUBN,
        PK_ZERO,
        PK_INF,
        PK_NAN,
        PK_OVF
    } pack_class_t;

endpackage

// File: rtl/packoutput_if.sv
// packoutput_if
// Purpose : bundles the producer-side entry handshake/fields and the consumer-side result
//           handshake/flags of the packer.
// Signals : in_valid/in_ready, fmt, sgn, exp, man, nan/inf/zero (entry);
//           out_valid/out_ready, res, overflow/underflow/inexact (result).
// Modports: master = FPU side driving entries and accepting results; slave = the packer.
interface packoutput_if;
    import packoutput_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [FMTBITS-1:0] fmt;
    logic               sgn;
    logic [NE-1:0]      exp;
    logic [NF:0]        man;
    logic               nan;
    logic               inf;
    logic               zero;
    logic               out_valid;
    logic               out_ready;
    logic [FLEN-1:0]    res;
    logic               overflow;
    logic               underflow;
    logic               inexact;

    modport master (
        output in_valid, fmt, sgn, exp, man, nan, inf, zero, out_ready,
        input  in_ready, out_valid, res, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, fmt, sgn, exp, man, nan, inf, zero, out_ready,
        output in_ready, out_valid, res, overflow, underflow, inexact
    );

endinterface

// File: rtl/packrebias.sv
// packrebias
// Purpose : combinational stage-1 logic. Rebiases the largest-precision exponent into the
//           target format, classifies the entry and computes the denormalising shift.
// Ports   : i_fmt target format, i_exp biased exponent (double bias), i_lead Man[NF],
//           i_nan/i_inf/i_zero input class; o_e rebiased exponent (low NE bits),
//           o_shift right shift for subnormals, o_class pack class.
module packrebias
    import packoutput_pkg::*;
(
    input  logic [FMTBITS-1:0] i_fmt,
    input  logic [NE-1:0]      i_exp,
    input  logic               i_lead,
    input  logic               i_nan,
    input  logic               i_inf,
    input  logic               i_zero,
    output logic [NE-1:0]      o_e,
    output logic [SHW-1:0]     o_shift,
    output pack_class_t        o_class
);

    logic signed [EW-1:0] w_ofs;
    logic signed [EW-1:0] w_emax;
    logic signed [EW-1:0] w_shmax;
    logic signed [EW-1:0] w_e;
    logic signed [EW-1:0] w_sh;

    always_comb begin
        // Double (and the unsupported Q encoding) need no rebias.
        w_ofs   = '0;
        w_emax  = EW'((1 << NE) - 1);
        w_shmax = EW'(SHMAX);
        case (i_fmt)
            FMT_S: begin
                w_ofs   = EW'(BIAS - S_BIAS);
                w_emax  = EW'((1 << S_NE) - 1);
                w_shmax = EW'(S_NF + 2);
            end
            FMT_H: begin
                w_ofs   = EW'(BIAS - H_BIAS);
                w_emax  = EW'((1 << H_NE) - 1);
                w_shmax = EW'(H_NF + 2);
            end
            default: ;
        endcase

        w_e  = $signed({2'b00, i_exp}) - w_ofs;
        w_sh = $signed(EW'(1)) - w_e;
        o_e  = w_e[NE-1:0];

        o_shift = '0;
        o_class = PK_NORM;
        if (i_nan) begin
            o_class = PK_NAN;
        end else if (i_inf) begin
            o_class = PK_INF;
        end else if (i_zero) begin
            o_class = PK_ZERO;
        end else if (w_e >= w_emax) begin
            o_class = PK_OVF;
        end else if (w_e <= 0 || !i_lead) begin
            o_class = PK_SUBN;
            // An unnormalised significand with a positive exponent is already aligned.
            if (w_sh < 0) begin
                o_shift = '0;
            end else if (w_sh > w_shmax) begin
                o_shift = w_shmax[SHW-1:0];
            end else begin
                o_shift = w_sh[SHW-1:0];
            end
        end
    end

endmodule

// File: rtl/packoutput.sv
// packoutput
// Purpose : packs an internal FP result into the IEEE encoding of the target format with
//           NaN-boxing, through a two-stage valid/ready pipeline (rebias, then assemble).
//           No rounding: discarded significand bits are reported through inexact.
// Ports   : clk, reset_n (async active-low), i_flush (sync kill of in-flight entries),
//           bus (packoutput_if.slave: entry handshake/fields, result handshake/res/flags).
module packoutput
    import packoutput_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    packoutput_if.slave  bus
);

    // Stage 1 registers
    logic               r_s1_valid;
    logic [FMTBITS-1:0] r_s1_fmt;
    logic               r_s1_sgn;
    logic [NE-1:0]      r_s1_e;
    logic [SHW-1:0]     r_s1_shift;
    logic [NF:0]        r_s1_man;
    pack_class_t        r_s1_class;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [FLEN-1:0]    r_res;
    logic               r_ovf;
    logic               r_unf;
    logic               r_inx;

    logic               w_s2_free;
    logic               w_s1_adv;
    logic               w_accept;
    logic [NE-1:0]      w_e;
    logic [SHW-1:0]     w_shift;
    pack_class_t        w_class;

    logic [XW-1:0]      w_ext;
    logic               w_exp_ones;
    logic               w_exp_zero;
    logic               w_frac_zero;
    logic               w_is_nan;
    logic               w_sign;
    logic               w_lost;
    logic               w_fmt_ok;
    logic               w_data;
    logic [S_NE-1:0]    w_exp_s;
    logic [S_NF-1:0]    w_frac_s;
    logic [NE-1:0]      w_exp_d;
    logic [NF-1:0]      w_frac_d;
    logic [H_NE-1:0]    w_exp_h;
    logic [H_NF-1:0]    w_frac_h;
    logic [FLEN-1:0]    w_res;
    logic               w_ovf;
    logic               w_unf;
    logic               w_inx;

    assign w_s2_free    = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv     = r_s1_valid & w_s2_free;
    assign bus.in_ready = ~r_s1_valid | w_s2_free;
    assign w_accept     = bus.in_valid & bus.in_ready;

    packrebias u_rebias (
        .i_fmt   (bus.fmt),
        .i_exp   (bus.exp),
        .i_lead  (bus.man[NF]),
        .i_nan   (bus.nan),
        .i_inf   (bus.inf),
        .i_zero  (bus.zero),
        .o_e     (w_e),
        .o_shift (w_shift),
        .o_class (w_class)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_fmt   <= '0;
            r_s1_sgn   <= 1'b0;
            r_s1_e     <= '0;
            r_s1_shift <= '0;
            r_s1_man   <= '0;
            r_s1_class <= PK_NORM;
        end else begin
            if (i_flush) begin
                r_s1_valid <= 1'b0;
            end else if (bus.in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_accept) begin
                r_s1_fmt   <= bus.fmt;
                r_s1_sgn   <= bus.sgn;
                r_s1_e     <= w_e;
                r_s1_shift <= w_shift;
                r_s1_man   <= bus.man;
                r_s1_class <= w_class;
            end
        end
    end

    // Stage 2 assembly: the shifted window holds the fraction just below the leading-bit
    // position, followed by every bit that the target format cannot keep.
    always_comb begin
        w_ext       = XW'({r_s1_man, {SHMAX{1'b0}}} >> r_s1_shift);
        w_exp_ones  = r_s1_class inside {PK_INF, PK_NAN, PK_OVF};
        w_exp_zero  = r_s1_class inside {PK_SUBN, PK_ZERO};
        w_frac_zero = r_s1_class inside {PK_INF, PK_OVF, PK_ZERO};
        w_is_nan    = (r_s1_class == PK_NAN);
        w_sign      = r_s1_sgn & ~w_is_nan;
        w_data      = r_s1_class inside {PK_NORM, PK_SUBN};
        w_lost      = 1'b0;
        w_fmt_ok    = 1'b1;
        w_exp_s     = '0;
        w_frac_s    = '0;
        w_exp_d     = '0;
        w_frac_d    = '0;
        w_exp_h     = '0;
        w_frac_h    = '0;
        w_res       = CANON_NAN_FLEN;
        case (r_s1_fmt)
            FMT_S: begin
                w_exp_s  = w_exp_ones ? {S_NE{1'b1}} :
                           (w_exp_zero ? {S_NE{1'b0}} : r_s1_e[S_NE-1:0]);
                w_frac_s = w_frac_zero ? {S_NF{1'b0}} :
                           (w_is_nan ? {1'b1, {(S_NF-1){1'b0}}} : w_ext[XW-1 -: S_NF]);
                w_lost   = |w_ext[XW-1-S_NF:0];
                w_res    = {{(FLEN-S_LEN){1'b1}}, w_sign, w_exp_s, w_frac_s};
            end
            FMT_D: begin
                w_exp_d  = w_exp_ones ? {NE{1'b1}} :
                           (w_exp_zero ? {NE{1'b0}} : r_s1_e);
                w_frac_d = w_frac_zero ? {NF{1'b0}} :
                           (w_is_nan ? {1'b1, {(NF-1){1'b0}}} : w_ext[XW-1 -: NF]);
                w_lost   = |w_ext[XW-1-NF:0];
                w_res    = {w_sign, w_exp_d, w_frac_d};
            end
            FMT_H: begin
                w_exp_h  = w_exp_ones ? {H_NE{1'b1}} :
                           (w_exp_zero ? {H_NE{1'b0}} : r_s1_e[H_NE-1:0]);
                w_frac_h = w_frac_zero ? {H_NF{1'b0}} :
                           (w_is_nan ? {1'b1, {(H_NF-1){1'b0}}} : w_ext[XW-1 -: H_NF]);
                w_lost   = |w_ext[XW-1-H_NF:0];
                w_res    = {{(FLEN-H_LEN){1'b1}}, w_sign, w_exp_h, w_frac_h};
            end
            default: w_fmt_ok = 1'b0;
        endcase
        w_ovf = w_fmt_ok & (r_s1_class == PK_OVF);
        w_inx = w_fmt_ok & ((w_data & w_lost) | (r_s1_class == PK_OVF));
        w_unf = w_fmt_ok & (r_s1_class == PK_SUBN) & w_lost;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
        end else begin
            if (i_flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
                r_inx <= w_inx;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.res       = r_res;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.inexact   = r_inx;

endmodule
